// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// State encoding is one-hot so each state decodes from a single bit.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 25;
  localparam int MEM_DATA_W = 16;
  localparam logic [1:0] BYTEENABLE = 2'b11;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ISSUE   = 5'b00010,
    ST_WAIT_RD = 5'b00100,
    ST_DONE    = 5'b01000,
    ST_RELEASE = 5'b10000
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-grant history register.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_id
);

  // Winner selection: a contested pick goes to whoever did not win last
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (enable) begin
      case (req)
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = ~last_grant;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end else begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one Avalon-MM SDRAM master between two requesters, one single-word
// transfer at a time, with a saturating per-transaction timeout.
module mem_req_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              gnt_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
  logic              timeout_s;
  logic              to_r, to_s;
  logic              last_grant_r, last_grant_s;
  logic              gnt_id_r, gnt_id_s;
  logic              grant_valid_s, grant_id_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              rd_r, rd_s, wr_r, wr_s;
  logic [1:0]        done_r, done_s;
  logic              err_r, err_s, busy_r, busy_s;

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant_r),
    .enable      (state_r == ST_IDLE),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    to_s         = to_r;
    last_grant_s = last_grant_r;
    gnt_id_s     = gnt_id_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    rd_s         = rd_r;
    wr_s         = wr_r;
    // Saturating count; the limit stays true once reached
    cnt_inc_s    = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
    timeout_s    = (cnt_inc_s == CNT_MAX);
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_s  = ST_ISSUE;
          gnt_id_s = grant_id_s;
          cnt_s    = CNT_ZERO;
          to_s     = 1'b0;
          addr_s   = grant_id_s ? addr1 : addr0;
          wdata_s  = grant_id_s ? wdata1 : wdata0;
          rd_s     = ~we[grant_id_s];
          wr_s     = we[grant_id_s];
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_s = cnt_inc_s;
        if (!avm_waitrequest) begin
          rd_s = 1'b0;
          wr_s = 1'b0;
          if (wr_r) begin
            state_s = ST_DONE;
          end else if (avm_readdatavalid) begin
            rdata_s = avm_readdata;
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT_RD;
          end
        end else if (timeout_s) begin
          rd_s    = 1'b0;
          wr_s    = 1'b0;
          to_s    = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        cnt_s = cnt_inc_s;
        if (avm_readdatavalid) begin
          rdata_s = avm_readdata;
          state_s = ST_DONE;
        end else if (timeout_s) begin
          to_s    = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT_RD;
        end
      end
      ST_DONE: begin
        state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold off until the owner lowers req so a held level is not replayed
        if (!req[gnt_id_r]) begin
          state_s      = ST_IDLE;
          last_grant_s = gnt_id_r;
        end else begin
          state_s      = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
      end
    endcase
    done_s = (state_r == ST_DONE) ? (gnt_id_r ? 2'b10 : 2'b01) : 2'b00;
    err_s  = (state_r == ST_DONE) & to_r;
    busy_s = (state_s != ST_IDLE);
  end

  // State, bus and requester-facing registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      to_r         <= 1'b0;
      last_grant_r <= 1'b1;
      gnt_id_r     <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      done_r       <= 2'b00;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      to_r         <= to_s;
      last_grant_r <= last_grant_s;
      gnt_id_r     <= gnt_id_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      rd_r         <= rd_s;
      wr_r         <= wr_s;
      done_r       <= done_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
    end
  end

  assign done           = done_r;
  assign err            = err_r;
  assign rdata          = rdata_r;
  assign avm_address    = addr_r;
  assign avm_read       = rd_r;
  assign avm_write      = wr_r;
  assign avm_writedata  = wdata_r;
  assign avm_byteenable = BYTEENABLE;
  assign busy           = busy_r;
  assign gnt_id         = gnt_id_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: a reactive Avalon slave plus a transaction-level model
// predicting beats, completion latency, error flag, read data and grant order.
module tb_mem_req_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [1:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          busy, gnt_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .err(err), .rdata(rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .gnt_id(gnt_id)
  );

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
  beat_t beats[$];
  beat_t b_tmp;

  // Slave configuration and observations
  int ws_cfg = 0, lat_cfg = 0, ws_done = 0, vcnt = -1;
  int stall_seen = 0, stable_viol = 0;
  logic [DW-1:0] rd_cfg = 16'h0000;
  logic [AW-1:0] sv_addr;
  logic [DW-1:0] sv_data;
  logic          sv_w;
  logic [DW-1:0] exp_rdata = 16'h0000;
  int model_last = 1;

  // Reactive slave: stalls ws_cfg cycles, returns read data lat_cfg cycles after acceptance
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (!reset_n) begin
      vcnt = -1; ws_done = 0; avm_waitrequest = 1'b0;
    end else begin
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          avm_readdatavalid = 1'b1; avm_readdata = rd_cfg; vcnt = -1;
        end
      end
      if (avm_read || avm_write) begin
        if (ws_done == 0) begin
          sv_addr = avm_address; sv_data = avm_writedata; sv_w = avm_write;
        end else if (avm_address !== sv_addr || avm_writedata !== sv_data || avm_write !== sv_w) begin
          stable_viol++;
        end
        if (ws_done < ws_cfg) begin
          avm_waitrequest = 1'b1; ws_done++; stall_seen++;
        end else begin
          avm_waitrequest = 1'b0;
          b_tmp.w = avm_write; b_tmp.a = avm_address; b_tmp.d = avm_writedata;
          beats.push_back(b_tmp);
          ws_done = ws_cfg + 1;
          if (avm_read && lat_cfg == 0) begin
            avm_readdatavalid = 1'b1; avm_readdata = rd_cfg;
          end else if (avm_read && lat_cfg > 0) begin
            vcnt = lat_cfg;
          end
        end
      end else begin
        avm_waitrequest = 1'b0; ws_done = 0;
      end
    end
  end

  // One single-requester transaction, predicted from the slave timing it is given
  task automatic run_txn(input int id, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ws, input int lat,
                         input logic [DW-1:0] rdv, input int hold, input string tag);
    int total, eff, cyc;
    bit got, timed;
    logic [1:0] exp_done;
    beats.delete(); stall_seen = 0; stable_viol = 0;
    ws_cfg = ws; lat_cfg = lat; rd_cfg = rdv;
    if (id == 0) begin addr0 = a; wdata0 = d; we[0] = w; end
    else begin addr1 = a; wdata1 = d; we[1] = w; end
    req[id] = 1'b1;
    total = ws + 1 + ((!w && lat > 0) ? lat : 0);
    timed = (!w && lat < 0) || (total > TO);
    eff = timed ? TO : total;
    exp_done = (id == 1) ? 2'b10 : 2'b01;
    if (!w && !timed) exp_rdata = rdv;
    cyc = 0; got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk); cyc++;
      if (done !== 2'b00) got = 1;
    end
    n_cmp++;
    if (!got || cyc != eff + 2) begin
      n_bad++; $display("FAIL %s latency: got=%0d cycles (seen=%0d) want=%0d", tag, cyc, got, eff + 2);
    end
    n_cmp++;
    if (done !== exp_done) begin n_bad++; $display("FAIL %s done: got=%b want=%b", tag, done, exp_done); end
    n_cmp++;
    if (err !== timed) begin n_bad++; $display("FAIL %s err: got=%b want=%b", tag, err, timed); end
    n_cmp++;
    if (rdata !== exp_rdata) begin n_bad++; $display("FAIL %s rdata: got=%h want=%h", tag, rdata, exp_rdata); end
    n_cmp++;
    if (gnt_id !== id[0]) begin n_bad++; $display("FAIL %s gnt_id: got=%b want=%0d", tag, gnt_id, id); end
    n_cmp++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
      n_bad++; $display("FAIL %s strobes: got rd=%b wr=%b want 0/0", tag, avm_read, avm_write);
    end
    n_cmp++;
    if (beats.size() != 1) begin
      n_bad++; $display("FAIL %s beats: got=%0d want=1", tag, beats.size());
    end else if (beats[0].w !== w || beats[0].a !== a || (w && beats[0].d !== d)) begin
      n_bad++; $display("FAIL %s beat: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                        tag, beats[0].w, beats[0].a, beats[0].d, w, a, d);
    end
    repeat (hold) @(negedge clk);
    n_cmp++;
    if (beats.size() != 1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL %s release_hold: got beats=%0d busy=%b want 1/1", tag, beats.size(), busy);
    end
    req[id] = 1'b0;
    model_last = id;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 2'b00) begin
      n_bad++; $display("FAIL %s back_idle: got busy=%b done=%b want 0/00", tag, busy, done);
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (done !== 2'b00 || err !== 1'b0 || rdata !== 16'h0000 || busy !== 1'b0 || gnt_id !== 1'b0 ||
        avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 25'h0 || avm_writedata !== 16'h0 ||
        avm_byteenable !== 2'b11) begin
      n_bad++; $display("FAIL reset_state: got done=%b err=%b rdata=%h busy=%b gnt=%b rd=%b wr=%b a=%h d=%h be=%b want all zero, be=11",
                        done, err, rdata, busy, gnt_id, avm_read, avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    run_txn(0, 1'b1, 25'h0000ABC, 16'h1234, 0, 0, 16'h0000, 0, "write0");
  endtask

  task automatic test_read;
    run_txn(1, 1'b0, 25'h1234567, 16'h0000, 0, 3, 16'hBEEF, 0, "read1");
  endtask

  task automatic test_waitrequest;
    run_txn(0, 1'b1, 25'h0155AA0, 16'hC0DE, 5, 0, 16'h0000, 0, "wait5");
    n_cmp++;
    if (stall_seen != 5 || stable_viol != 0) begin
      n_bad++; $display("FAIL wait5_stable: got stalls=%0d changes=%0d want 5/0", stall_seen, stable_viol);
    end
  endtask

  task automatic test_timeout;
    run_txn(1, 1'b0, 25'h0000777, 16'h0000, 0, -1, 16'h5A5A, 0, "timeout");
  endtask

  task automatic test_no_double;
    run_txn(0, 1'b1, 25'h1FFFFFF, 16'hFFFF, 1, 0, 16'h0000, 6, "held_req");
  endtask

  task automatic test_back_to_back;
    int ndone = 0, cyc = 0, exp_id;
    logic [AW-1:0] ea;
    beats.delete(); ws_cfg = 0; lat_cfg = 0;
    we = 2'b11; addr0 = 25'h0000100; addr1 = 25'h0000200;
    wdata0 = DW'($urandom); wdata1 = DW'($urandom);
    req = 2'b11;
    while (ndone < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      req = 2'b11;
      if (done !== 2'b00) begin
        exp_id = (model_last == 0) ? 1 : 0;
        ea = (exp_id == 1) ? addr1 : addr0;
        n_cmp++;
        if (done !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL rr_order#%0d: got done=%b want requester %0d", ndone, done, exp_id);
        end
        n_cmp++;
        if (beats.size() != ndone + 1 || beats[beats.size() - 1].a !== ea) begin
          n_bad++; $display("FAIL rr_beat#%0d: got beats=%0d want %0d at addr %h", ndone, beats.size(), ndone + 1, ea);
        end
        model_last = exp_id;
        req[exp_id] = 1'b0;
        ndone++;
      end
    end
    n_cmp++;
    if (ndone != 4) begin n_bad++; $display("FAIL rr_count: got=%0d want=4", ndone); end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    int id, ws, lat, hold;
    logic w;
    logic [DW-1:0] rdv;
    for (int i = 0; i < 24; i++) begin
      id = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      ws = int'($urandom_range(0, 3));
      lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 2));
      rdv = DW'($urandom);
      run_txn(id, w, AW'($urandom), DW'($urandom), ws, lat, rdv, hold, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    beats.delete(); ws_cfg = 0; lat_cfg = -1;
    we[1] = 1'b0; addr1 = 25'h0ABCDEF; req = 2'b10;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || avm_read !== 1'b0 || beats.size() != 1) begin
      n_bad++; $display("FAIL mid_wait_rd: got busy=%b rd=%b beats=%0d want 1/0/1", busy, avm_read, beats.size());
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || err !== 1'b0 ||
        rdata !== 16'h0000 || gnt_id !== 1'b0 || avm_address !== 25'h0 || avm_writedata !== 16'h0) begin
      n_bad++; $display("FAIL async_reset: got rd=%b wr=%b busy=%b done=%b err=%b rdata=%h gnt=%b a=%h want all zero",
                        avm_read, avm_write, busy, done, err, rdata, gnt_id, avm_address);
    end
    exp_rdata = 16'h0000; model_last = 1;
    req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ws_cfg = 0; lat_cfg = 0;
    we = 2'b11; req = 2'b11;
    while (done === 2'b00 && cyc < 30) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (done !== 2'b01) begin n_bad++; $display("FAIL first_after_reset: got done=%b want 01", done); end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 25'h0; addr1 = 25'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    avm_waitrequest = 1'b0; avm_readdata = 16'h0000; avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_waitrequest();
    test_timeout();
    test_no_double();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
